// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial sequencer for a single 1-bit ALU slice.
// Feeds latched operands to the slice one bit per cycle (LSB first),
// chains the slice carry, assembles the full-width result and forms c/z/o/s.
// Optional feature macro: ALU_SEQ_ABORT_EN adds an abort input that cancels
// a running operation (no done pulse, partial result/flags are kept).
//
// Handshake: start is sampled only in IDLE or DONE; an accepted start
// launches WIDTH RUN cycles, then done pulses high for exactly one cycle
// while result/flags are valid. busy is high for every RUN cycle.
module alu_serial_seq #(
  parameter int WIDTH = 128,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ALU_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin_in,
  input  logic [2:0]       opsel_in,
  input  logic             mode_in,
  output logic             slice_op1,
  output logic             slice_op2,
  output logic             slice_cin,
  output logic [2:0]       slice_opsel,
  output logic             slice_mode,
  input  logic             slice_result,
  input  logic             slice_c,
  input  logic             slice_o,
  input  logic             slice_z,
  input  logic             slice_s,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_flag,
  output logic             z_flag,
  output logic             o_flag,
  output logic             s_flag,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       opsel_q;
  logic             mode_q;
  logic             carry_q;
  logic             zacc;

  logic running;
  logic last_bit;
  logic abort_run;

  // The slice computes z and s per bit; both flags are formed here instead.
  logic unused_slice_flags;
  assign unused_slice_flags = slice_z ^ slice_s;

  assign running   = (state == RUN);
  assign last_bit  = (idx == IDXW'(WIDTH - 1));
  assign dbg_state = state;

`ifdef ALU_SEQ_ABORT_EN
  assign abort_run = abort && running;
`else
  assign abort_run = 1'b0;
`endif

  // Slice drive: current bit pair and chained carry in RUN, quiet otherwise.
  always_comb begin
    slice_op1   = 1'b0;
    slice_op2   = 1'b0;
    slice_cin   = 1'b0;
    slice_opsel = 3'b000;
    slice_mode  = 1'b0;
    if (running) begin
      slice_op1   = a_q[idx];
      slice_op2   = b_q[idx];
      slice_cin   = carry_q;
      slice_opsel = opsel_q;
      slice_mode  = mode_q;
    end
  end

  // Sequencer FSM with registered busy/done, result assembly and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      opsel_q <= 3'b000;
      mode_q  <= 1'b0;
      carry_q <= 1'b0;
      zacc    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      c_flag  <= 1'b0;
      z_flag  <= 1'b0;
      o_flag  <= 1'b0;
      s_flag  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          busy <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            opsel_q <= opsel_in;
            mode_q  <= mode_in;
            carry_q <= cin_in;
            zacc    <= 1'b0;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (abort_run) begin
            // Cancelled: keep whatever result/flag bits were already written.
            busy  <= 1'b0;
            idx   <= '0;
            state <= IDLE;
          end else begin
            result[idx] <= slice_result;
            carry_q     <= slice_c;
            zacc        <= zacc | slice_result;
            if (last_bit) begin
              c_flag <= slice_c;
              o_flag <= slice_o;
              s_flag <= slice_result;
              z_flag <= ~(zacc | slice_result);
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              idx <= idx + IDXW'(1);
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq: directed bench for alu_serial_seq with a behavioural
// add slice (opsel=000, mode=0). Expected {result,c,z,o,s} tuples are queued
// at issue time and checked by a monitor whenever done is seen.
module tb_alu_serial_seq;

  localparam int W = 128;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin_in = 1'b0;
  logic [2:0]   opsel_in = 3'b000;
  logic         mode_in = 1'b0;
`ifdef ALU_SEQ_ABORT_EN
  logic         abort = 1'b0;
`endif

  logic         slice_op1, slice_op2, slice_cin, slice_mode;
  logic [2:0]   slice_opsel;
  logic         slice_result, slice_c, slice_o, slice_z, slice_s;
  logic         busy, done;
  logic [W-1:0] result;
  logic         c_flag, z_flag, o_flag, s_flag;
  logic [1:0]   dbg_state;

  // Scoreboard state
  logic [W+3:0] exp_q[$];
  int           n_total = 0;
  int           n_pass = 0;
  int           done_count = 0;
  int           busy_cnt = 0;
  int           last_busy = 0;
  int           cyc = 0;
  int           prev_done_cyc = 0;
  int           last_gap = 0;
  logic         prev_done = 1'b0;

  localparam logic [W-1:0] ALL1 = {W{1'b1}};
  localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef ALU_SEQ_ABORT_EN
    .abort        (abort),
`endif
    .start        (start),
    .a            (a),
    .b            (b),
    .cin_in       (cin_in),
    .opsel_in     (opsel_in),
    .mode_in      (mode_in),
    .slice_op1    (slice_op1),
    .slice_op2    (slice_op2),
    .slice_cin    (slice_cin),
    .slice_opsel  (slice_opsel),
    .slice_mode   (slice_mode),
    .slice_result (slice_result),
    .slice_c      (slice_c),
    .slice_o      (slice_o),
    .slice_z      (slice_z),
    .slice_s      (slice_s),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .c_flag       (c_flag),
    .z_flag       (z_flag),
    .o_flag       (o_flag),
    .s_flag       (s_flag),
    .dbg_state    (dbg_state)
  );

  // Behavioural add slice
  assign slice_result = slice_op1 ^ slice_op2 ^ slice_cin;
  assign slice_c      = (slice_op1 & slice_op2) | (slice_op1 & slice_cin) | (slice_op2 & slice_cin);
  assign slice_o      = slice_cin ^ slice_c;
  assign slice_z      = 1'b0;
  assign slice_s      = 1'b0;

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor: sample away from the active edge, pop and compare on done
  always @(negedge clk) begin
    logic [W+3:0] e;
    if (rst) busy_cnt = 0;
    else if (busy) busy_cnt++;
    if (done) begin
      done_count++;
      last_gap      = cyc - prev_done_cyc;
      prev_done_cyc = cyc;
      last_busy     = busy_cnt;
      busy_cnt      = 0;
      chk("done_single_cycle", W'(prev_done), W'(0));
      chk("done_expected", W'(exp_q.size() != 0), W'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("result", result, e[W+3:4]);
        chk("c_flag", W'(c_flag), W'(e[3]));
        chk("z_flag", W'(z_flag), W'(e[2]));
        chk("o_flag", W'(o_flag), W'(e[1]));
        chk("s_flag", W'(s_flag), W'(e[0]));
      end
    end
    prev_done = done;
  end

  // Driver: present one operation; returns #1 after the accepting edge
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                       input logic [W+3:0] e);
    a      = ta;
    b      = tb_v;
    cin_in = tc;
    start  = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = {4{$urandom}};
    b     = {4{$urandom}};
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 400 && done_count < target; i++) @(posedge clk);
    #1;
    chk("done_timeout", W'(done_count >= target), W'(1));
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, W'(busy), W'(0));
    chk({tag, "_done"}, W'(done), W'(0));
    chk({tag, "_result"}, result, W'(0));
    chk({tag, "_flags"}, W'({c_flag, z_flag, o_flag, s_flag}), W'(0));
    chk({tag, "_state"}, W'(dbg_state), W'(0));
  endtask

  initial begin
    int base;
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    chk("reset_slice_outs", W'({slice_op1, slice_op2, slice_cin, slice_opsel, slice_mode}), W'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Add wrap: all-ones + 1
    issue(ALL1, W'(1), 1'b0, {W'(0), 1'b1, 1'b1, 1'b0, 1'b0});
    wait_done(1);
    chk("busy_len", W'(last_busy), W'(128));

    // Signed overflow: 2^127-1 + 1
    issue(MAXP, W'(1), 1'b0, {MSB, 1'b0, 1'b0, 1'b1, 1'b1});
    wait_done(2);

    // Carry-in path: 5 + 7 + 1
    issue(W'(5), W'(7), 1'b1, {W'(13), 1'b0, 1'b0, 1'b0, 1'b0});
    wait_done(3);
    repeat (5) @(posedge clk);
    #1;
    chk("result_held", result, W'(13));

    // Zero operands
    issue(W'(0), W'(0), 1'b0, {W'(0), 1'b0, 1'b1, 1'b0, 1'b0});
    wait_done(4);

    // MSB + MSB: carry out and signed overflow, zero result
    issue(MSB, MSB, 1'b0, {W'(0), 1'b1, 1'b1, 1'b1, 1'b0});
    wait_done(5);

    // Back-to-back with start held high
    base = done_count;
    for (int k = 0; k < 3; k++) exp_q.push_back({W'(7), 1'b0, 1'b0, 1'b0, 1'b0});
    a = W'(3); b = W'(4); cin_in = 1'b0; start = 1'b1;
    for (int i = 0; i < 600 && done_count < base + 2; i++) @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_gap", W'(last_gap), W'(129));
    wait_done(base + 3);
    chk("b2b_gap_last", W'(last_gap), W'(129));

    // Reset mid-op at idx 60
    @(posedge clk);
    #1;
    issue(W'(3), W'(4), 1'b0, {W'(7), 1'b0, 1'b0, 1'b0, 1'b0});
    repeat (60) @(posedge clk);
    #1;
    rst = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_cleared("midreset");
    base = done_count;
    repeat (200) @(posedge clk);
    #1;
    chk("no_done_after_reset", W'(done_count), W'(base));

`ifdef ALU_SEQ_ABORT_EN
    // Abort at idx 10
    issue(ALL1, ALL1, 1'b0, {W'(0), 4'b0000});
    repeat (10) @(posedge clk);
    #1;
    abort = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_state", W'(dbg_state), W'(0));
    chk("abort_partial", W'(result[9:0]), W'(10'h3FE));
    base = done_count;
    repeat (150) @(posedge clk);
    #1;
    chk("no_done_after_abort", W'(done_count), W'(base));
    issue(W'(5), W'(7), 1'b1, {W'(13), 1'b0, 1'b0, 1'b0, 1'b0});
    wait_done(base + 1);
`endif

    chk("queue_empty", W'(exp_q.size()), W'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
